// File: rtl/inst_mem_ctrl.sv
// Instruction memory: NOP-filled at reset, byte-enabled program loads, one fetch per cycle.
// Fetch latency 1 cycle; fetch_ready is low only during the DEPTH_WORDS-cycle fill.
module inst_mem_ctrl #(
  parameter int          DEPTH_WORDS = 16,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           fetch_req,
  input  logic [31:0]                    PC,
  output logic                           fetch_ready,
  output logic [31:0]                    Instruction_Code,
  output logic                           instr_valid,
  output logic                           instr_fault,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data,
  input  logic [3:0]                     load_be,
  output logic                           init_done
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t         state_q;
  logic [AW-1:0]  cnt_q;
  logic [AW-1:0]  cnt_d;
  logic           vld_q;
  logic           fault_q;
  logic [31:0]    code_q;
  logic [31:0]    mem_q [DEPTH_WORDS];

  logic [AW-1:0]  rd_idx;
  logic           pc_fault;

  assign cnt_d  = cnt_q + 1'b1;
  assign rd_idx = PC[AW+1:2];
  // Any set bit above the word index means the PC is past the end; never wrap.
  assign pc_fault = (PC[1:0] != 2'b00) || (PC[31:AW+2] != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= NOP_WORD;
    end else begin
      vld_q   <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_d;
          if (cnt_q == AW'(DEPTH_WORDS - 1)) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (fetch_req) begin
            vld_q   <= 1'b1;
            fault_q <= pc_fault;
            code_q  <= pc_fault ? NOP_WORD : mem_q[rd_idx];
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  // Read in the block above sees the old word, giving read-before-write on collisions.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q] <= NOP_WORD;
    end else if (load_en) begin
      for (int b = 0; b < 4; b++) begin
        if (load_be[b]) begin
          mem_q[load_addr][8*b +: 8] <= load_data[8*b +: 8];
        end
      end
    end
  end

  assign fetch_ready      = (state_q == ST_RUN);
  assign init_done        = (state_q == ST_RUN);
  assign instr_valid      = vld_q;
  assign instr_fault      = fault_q;
  assign Instruction_Code = code_q;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Directed and randomized checks of inst_mem_ctrl against a word-array reference model.
module tb_inst_mem_ctrl;

  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic [31:0] PC;
  logic        fetch_ready;
  logic [31:0] Instruction_Code;
  logic        instr_valid;
  logic        instr_fault;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [31:0] load_data;
  logic [3:0]  load_be;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] last_code;

  inst_mem_ctrl #(.DEPTH_WORDS(DEPTH), .NOP_WORD(NOP)) dut (
    .clk              (clk),
    .reset            (reset),
    .fetch_req        (fetch_req),
    .PC               (PC),
    .fetch_ready      (fetch_ready),
    .Instruction_Code (Instruction_Code),
    .instr_valid      (instr_valid),
    .instr_fault      (instr_fault),
    .load_en          (load_en),
    .load_addr        (load_addr),
    .load_data        (load_data),
    .load_be          (load_be),
    .init_done        (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = NOP;
    last_code = NOP;
  endtask

  // One RUN-mode cycle: drive, predict from the model, clock, compare.
  task automatic cyc(input logic req, input logic [31:0] pc, input logic ld,
                     input logic [3:0] a, input logic [31:0] d, input logic [3:0] be,
                     input string tag);
    logic        flt;
    logic [31:0] exp;
    fetch_req = req;
    PC        = pc;
    load_en   = ld;
    load_addr = a;
    load_data = d;
    load_be   = be;
    flt = (pc % 4 != 0) || (pc >= 4 * DEPTH);
    exp = NOP;
    if (!flt) exp = mem_m[int'(pc / 4)];
    if (ld) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_m[a][8*b +: 8] = d[8*b +: 8];
    end
    step();
    fetch_req = 1'b0;
    load_en   = 1'b0;
    chk({tag, ".vld"}, 32'(instr_valid), 32'(req));
    if (req) begin
      chk({tag, ".code"}, Instruction_Code, exp);
      chk({tag, ".fault"}, 32'(instr_fault), 32'(flt));
      last_code = exp;
    end else begin
      chk({tag, ".hold"}, Instruction_Code, last_code);
      chk({tag, ".nofault"}, 32'(instr_fault), 32'd0);
    end
  endtask

  task automatic do_reset(input logic with_fetch, input string tag);
    if (with_fetch) begin
      fetch_req = 1'b1;
      PC        = 32'h0;
    end
    #1 reset = 1'b1;
    #1;
    chk({tag, ".rst_vld"},   32'(instr_valid), 32'd0);
    chk({tag, ".rst_fault"}, 32'(instr_fault), 32'd0);
    chk({tag, ".rst_done"},  32'(init_done),   32'd0);
    chk({tag, ".rst_rdy"},   32'(fetch_ready), 32'd0);
    chk({tag, ".rst_code"},  Instruction_Code, NOP);
    step();
    step();
    chk({tag, ".rst_hold_vld"}, 32'(instr_valid), 32'd0);
    #3 reset = 1'b0;
    fetch_req = 1'b0;
    model_clear();
  endtask

  // Fetches and loads are offered all through the fill; none may take effect.
  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < 40) begin
      chk({tag, ".init_rdy"}, 32'(fetch_ready), 32'd0);
      fetch_req = 1'b1;
      PC        = 32'(4 * (n % DEPTH));
      load_en   = 1'b1;
      load_addr = 4'(n);
      load_data = $urandom;
      load_be   = 4'hF;
      step();
      n++;
      chk({tag, ".init_vld"}, 32'(instr_valid), 32'd0);
    end
    fetch_req = 1'b0;
    load_en   = 1'b0;
    chk({tag, ".init_len"}, 32'(n), 32'd16);
    chk({tag, ".run_rdy"},  32'(fetch_ready), 32'd1);
  endtask

  initial begin
    reset     = 1'b0;
    fetch_req = 1'b0;
    PC        = '0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    load_be   = '0;
    model_clear();
    step();

    do_reset(1'b0, "por");
    wait_init("por");

    cyc(1'b1, 32'h3C, 1'b0, 4'd0, 32'h0, 4'h0, "nop_fill");
    chk("nop_fill.const", Instruction_Code, 32'h0000_0013);

    cyc(1'b0, 32'h0, 1'b1, 4'd0, 32'h3094_0333, 4'hF, "ld0");
    cyc(1'b0, 32'h0, 1'b1, 4'd1, 32'h20A5_8633, 4'hF, "ld1");
    cyc(1'b1, 32'h0, 1'b0, 4'd0, 32'h0, 4'h0, "f0");
    chk("f0.const", Instruction_Code, 32'h3094_0333);
    cyc(1'b1, 32'h4, 1'b0, 4'd0, 32'h0, 4'h0, "f4");
    chk("f4.const", Instruction_Code, 32'h20A5_8633);

    cyc(1'b0, 32'h0, 1'b1, 4'd2, 32'h035A_02B3, 4'hF, "ld2");
    cyc(1'b0, 32'h0, 1'b1, 4'd2, 32'hFFFF_FFFF, 4'b0101, "ld2be");
    cyc(1'b1, 32'h8, 1'b0, 4'd0, 32'h0, 4'h0, "f8");
    chk("f8.const", Instruction_Code, 32'h03FF_02FF);

    cyc(1'b0, 32'h0, 1'b1, 4'd0, 32'hFFFF_FFFF, 4'h0, "ld_be0");
    cyc(1'b1, 32'h0, 1'b0, 4'd0, 32'h0, 4'h0, "f0_be0");
    chk("f0_be0.const", Instruction_Code, 32'h3094_0333);

    cyc(1'b1, 32'h6, 1'b0, 4'd0, 32'h0, 4'h0, "mis");
    chk("mis.fault", 32'(instr_fault), 32'd1);
    cyc(1'b1, 32'h40, 1'b0, 4'd0, 32'h0, 4'h0, "oor");
    chk("oor.fault", 32'(instr_fault), 32'd1);
    chk("oor.code", Instruction_Code, 32'h0000_0013);

    cyc(1'b1, 32'hC, 1'b1, 4'd3, 32'h017B_4E33, 4'hF, "rbw");
    chk("rbw.old", Instruction_Code, 32'h0000_0013);
    cyc(1'b1, 32'hC, 1'b0, 4'd0, 32'h0, 4'h0, "rbw_next");
    chk("rbw_next.new", Instruction_Code, 32'h017B_4E33);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc;
      int          r;
      r = $urandom_range(0, 9);
      if (r < 7)       pc = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (r == 7) pc = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else if (r == 8) pc = 32'(4 * DEPTH + $urandom_range(0, 255));
      else             pc = $urandom;
      cyc(1'($urandom_range(0, 3) != 0), pc, 1'($urandom_range(0, 1)),
          4'($urandom_range(0, DEPTH - 1)), $urandom, 4'($urandom_range(0, 15)), "rnd");
    end

    cyc(1'b0, 32'h0, 1'b1, 4'd5, 32'hDEAD_BEEF, 4'hF, "pre_rst_ld");
    do_reset(1'b1, "flight");
    wait_init("flight");
    cyc(1'b1, 32'h14, 1'b0, 4'd0, 32'h0, 4'h0, "post_rst");
    chk("post_rst.nop", Instruction_Code, 32'h0000_0013);

    do_reset(1'b0, "mid_a");
    for (int i = 0; i < 7; i++) begin
      step();
      chk("mid_a.vld", 32'(instr_valid), 32'd0);
    end
    do_reset(1'b0, "mid_b");
    wait_init("mid_b");
    cyc(1'b1, 32'h0, 1'b0, 4'd0, 32'h0, 4'h0, "mid_b_f0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_mem_ctrl.md
INST_MEM_CTRL -- requirements
Module: inst_mem_ctrl

Interface
REQ-001 SHALL provide parameter DEPTH_WORDS, default 16, meaning number of 32-bit instruction words stored (power of two, 4..1024).
REQ-002 SHALL provide parameter NOP_WORD, default 32'h00000013, meaning the fill and fault instruction (addi x0,x0,0).
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port fetch_req  input  1  fetch request, qualified by fetch_ready.
REQ-006 SHALL provide port PC  input  32  byte address of the requested instruction.
REQ-007 SHALL provide port fetch_ready  output  1  block accepts a fetch this cycle.
REQ-008 SHALL provide port Instruction_Code  output  32  fetched instruction word.
REQ-009 SHALL provide port instr_valid  output  1  Instruction_Code is a fresh response this cycle.
REQ-010 SHALL provide port instr_fault  output  1  fresh response is for a misaligned or out-of-range PC.
REQ-011 SHALL provide port load_en  input  1  program-load write strobe.
REQ-012 SHALL provide port load_addr  input  log2(DEPTH_WORDS)  word index for the load write.
REQ-013 SHALL provide port load_data  input  32  load write data, little-endian bytes.
REQ-014 SHALL provide port load_be  input  4  byte enables for load_data; bit n covers byte n.
REQ-015 SHALL provide port init_done  output  1  memory fill complete; block operational.

Function
REQ-016 SHALL implement states INIT and RUN; reset forces INIT with fill counter 0.
REQ-017 In INIT, each cycle SHALL write NOP_WORD to word[counter] and increment counter; after word DEPTH_WORDS-1 is written, next state SHALL be RUN.
REQ-018 INIT SHALL last exactly DEPTH_WORDS cycles after reset deassertion; init_done and fetch_ready SHALL be 0 throughout INIT and 1 throughout RUN.
REQ-019 In INIT, fetch_req and load_en SHALL be ignored (no response, no write).
REQ-020 A fetch SHALL be accepted when fetch_req=1 and fetch_ready=1; the response SHALL appear the following cycle with instr_valid=1 for exactly one cycle.
REQ-021 One fetch per cycle SHALL be sustainable: back-to-back accepted fetches produce back-to-back responses in order.
REQ-022 Instruction_Code SHALL be {byte3,byte2,byte1,byte0} of word PC[2+:log2(DEPTH_WORDS)], byte0 at lowest address (little-endian).
REQ-023 If PC[1:0]!=0 or PC>=4*DEPTH_WORDS, the response SHALL carry instr_fault=1 and Instruction_Code=NOP_WORD; memory SHALL NOT be read for wrap-around.
REQ-024 When instr_valid=0, Instruction_Code SHALL hold its last value and instr_fault SHALL be 0.
REQ-025 In RUN, load_en=1 SHALL write each byte of word[load_addr] whose load_be bit is 1; other bytes unchanged.
REQ-026 Simultaneous accepted fetch and load to the same word SHALL return the pre-write data (read-before-write); the write SHALL be visible to the next fetch.
REQ-027 load_be=4'b0000 with load_en=1 SHALL leave memory unchanged.

Reset
REQ-028 Reset assertion SHALL immediately clear instr_valid, instr_fault, init_done, fetch_ready and set Instruction_Code=NOP_WORD.
REQ-029 Reset asserted mid-INIT or mid-RUN SHALL restart INIT from counter 0; an in-flight fetch response SHALL be dropped.
REQ-030 Memory contents SHALL be defined only via INIT fill and loads, never left uninitialised after init_done=1.

Verification
REQ-031 Reset release, DEPTH_WORDS=16 -> init_done rises exactly 16 cycles later; fetch PC=0x3C -> next cycle instr_valid=1, Instruction_Code=0x00000013, instr_fault=0.
REQ-032 Load addr 0 data 0x3094_0333 be=1111, addr 1 data 0x20A5_8633 -> fetches PC=0 then PC=4 back-to-back return 0x30940333, 0x20A58633 on consecutive cycles.
REQ-033 Load addr 2 data 0x035A02B3 be=1111, then addr 2 data 0xFFFFFFFF be=0101 -> fetch PC=8 returns 0x03FF02FF.
REQ-034 Fetch PC=0x6 -> instr_fault=1, Instruction_Code=0x00000013; fetch PC=0x40 (DEPTH 16) -> instr_fault=1, same code.
REQ-035 Same cycle: fetch PC=0xC and load addr 3 data 0x017B4E33 (prior 0x13) -> response 0x00000013; next fetch PC=0xC -> 0x017B4E33.
REQ-036 Reset pulse at INIT cycle 7, and again with a fetch in flight -> no instr_valid pulse; init_done rises 16 cycles after each release.
